// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/state sizes and the InvSubBytes engine FSM encoding.
package aes_pkg;
    localparam int AES_BYTE_W      = 8;
    localparam int AES_STATE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;
endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward AES S-box; only instantiated when INV_SUB_BYTES_SELFCHECK_EN is defined.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] value,
    output logic [AES_BYTE_W-1:0] result
);
    localparam logic [0:255][7:0] FWD_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign result = FWD_TAB[value];
endmodule

// File: rtl/inv_sbox.sv
// FIPS-197 inverse AES S-box, purely combinational lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] value,
    output logic [AES_BYTE_W-1:0] result
);
    localparam logic [0:255][7:0] INV_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign result = INV_TAB[value];
endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Iterative InvSubBytes: one state byte per cycle through a single inverse S-box.
// Optional round-trip self-check compiled in with INV_SUB_BYTES_SELFCHECK_EN.
module inv_sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int NBYTES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AES_BYTE_W*NBYTES-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [AES_BYTE_W*NBYTES-1:0] out_data,
    output logic                         chk_err
);
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    fsm_t                                 fsm;
    fsm_t                                 fsm_nxt;
    logic [3:0]                           idx;
    logic [NBYTES-1:0][AES_BYTE_W-1:0]    state;
    logic [AES_BYTE_W-1:0]                cur;
    logic [AES_BYTE_W-1:0]                inv_out;
    logic                                 accept;

    assign cur      = state[idx];
    assign out_data = state;
    assign accept   = in_valid && in_ready;

    inv_sbox u_inv_sbox (
        .value  (cur),
        .result (inv_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    // in_ready is gated by rst_n so it stays low for the whole reset assertion
    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) fsm_nxt = RUN;
            end
            RUN: begin
                if (idx == LAST_IDX) fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            idx   <= '0;
        end else if (accept) begin
            state <= in_data;
            idx   <= '0;
        end else if (fsm == RUN) begin
            state[idx] <= inv_out;
            if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
    end

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    logic [AES_BYTE_W-1:0] fwd_out;
    logic                  chk_q;

    aes_sbox u_sbox (
        .value  (inv_out),
        .result (fwd_out)
    );

    // Sticky until the next accepted state or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              chk_q <= 1'b0;
        else if (accept)                         chk_q <= 1'b0;
        else if (fsm == RUN && fwd_out != cur)   chk_q <= 1'b1;
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: doc/inv_sub_bytes_engine.md
INV_SUB_BYTES_ENGINE -- requirements
Module: inv_sub_bytes_engine

Interface
REQ-001 SHALL have parameter: NBYTES, 16, number of state bytes processed per transaction (legal 1..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  input state offered.
REQ-005 SHALL have port: in_ready  output  1  engine can accept a state.
REQ-006 SHALL have port: in_data  input  8*NBYTES  ciphertext-side state; byte i = bits [8i+7:8i].
REQ-007 SHALL have port: out_valid  output  1  result available.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-009 SHALL have port: out_data  output  8*NBYTES  InvSubBytes(in_data), same byte mapping.
REQ-010 SHALL have port: chk_err  output  1  sticky round-trip mismatch flag (see Configuration).

Function
REQ-011 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-013 SHALL capture in_data into an internal state register, clear byte index idx to 0 and enter RUN on a clock edge where in_valid && in_ready.
REQ-014 SHALL, in RUN, replace state byte idx with inv_sbox(byte idx) each cycle, one byte per cycle, ascending from byte 0.
REQ-015 SHALL enter DONE on the cycle byte NBYTES-1 is written; with NBYTES=1, RUN lasts exactly one cycle.
REQ-016 SHALL have a latency from the accept edge to the first cycle with out_valid=1 of exactly NBYTES cycles.
REQ-017 SHALL drive out_data from the state register and hold it stable while out_valid && !out_ready.
REQ-018 SHALL return to IDLE on an edge with out_valid && out_ready, with in_ready=1 on the next cycle; no overlap of input accept with output hold (throughput 1 state per NBYTES+2 cycles minimum).
REQ-019 SHALL ignore in_valid and in_data outside IDLE; in_data changes after the accept edge have no effect.
REQ-020 SHALL treat idx as a 4-bit counter that never exceeds NBYTES-1; no wrap-around occurs inside a transaction.
REQ-021 SHALL implement an inv_sbox that is the exact FIPS-197 inverse of the forward AES S-box for all 256 inputs.

Reset
REQ-022 SHALL, on rst_n low and at any time including mid-RUN, immediately force FSM=IDLE, idx=0, state register=0, out_data=0, out_valid=0, in_ready=0 while reset is asserted, and chk_err=0.
REQ-023 SHALL drive in_ready=1 on the first cycle after rst_n deasserts; a partially processed state is discarded.

Configuration
REQ-024 SHALL use the macro INV_SUB_BYTES_SELFCHECK_EN to compile the self-check in or out.
REQ-025 SHALL, with INV_SUB_BYTES_SELFCHECK_EN defined, feed each RUN-cycle inv_sbox output through the existing forward sbox, compare it with the original byte, and set chk_err on mismatch.
REQ-026 SHALL, with self-check enabled, hold chk_err until reset or the next accept edge, which clears it.
REQ-027 SHALL, without INV_SUB_BYTES_SELFCHECK_EN, instantiate no forward sbox and tie chk_err to 0; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/RUN/DONE), AES_BYTE_W=8 and AES_STATE_BYTES=16 in shared package aes_pkg.
REQ-029 SHALL implement one sub-module, inv_sbox (8-bit in, 8-bit out, combinational table), instantiated once; no other sub-module except the forward sbox under self-check.

Verification
REQ-030 SHALL cover: NBYTES=16, in_data all bytes 0x63, out_ready=1 -> out_data all 0x00, out_valid rises exactly 16 cycles after accept.
REQ-031 SHALL cover: in_data bytes 0x00,0x16,0x7C,0x63 (bytes 0..3), remainder 0x00 -> out bytes 0x52,0xFF,0x01,0x00, remainder 0x52.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_data stable, out_valid=1 and in_ready=0 throughout; in_valid pulsed meanwhile is not accepted.
REQ-033 SHALL cover: rst_n asserted at idx=7 -> out_valid=0 and out_data=0 immediately; after release, a new state 0x63.. is processed correctly.
REQ-034 SHALL cover: self-check enabled, inv_sbox output forced to 0xAA for one RUN cycle -> chk_err=1 and sticky until the next accept, then 0.
REQ-035 SHALL cover: all 256 byte values streamed (16 transactions) -> each output equals the FIPS-197 inverse table, and chk_err stays 0.
